// File: rtl/sng_scheduler.sv
// ============================================================================
// Module   : sng_scheduler
// Brief    : Round-robin scheduler sharing one LFSR-based stochastic number
//            generator among R requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sng_scheduler #(
   parameter int N     = 8,
   parameter int R     = 4,
   parameter int LEN_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [R-1:0]       i_req,
   input  logic [R*N-1:0]     i_req_value,
   input  logic [R*LEN_W-1:0] i_req_len,
   input  logic               i_hold,
   input  logic [N-1:0]       i_lfsr_data,
   output logic               o_lfsr_enable,
   output logic               o_lfsr_restart,
   output logic [R-1:0]       o_grant,
   output logic               o_bit_out,
   output logic               o_bit_valid,
   output logic               o_bit_last,
   output logic               o_busy
);

   localparam int PTR_W = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_win;
   logic [PTR_W-1:0]   w_win;
   logic               w_found;
   logic [N-1:0]       r_val;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_cnt;
   logic [R-1:0]       r_grant;
   logic               r_bit_out;
   logic               r_bit_valid;
   logic               r_bit_last;
   logic               w_cnt_last;

   // Adds an offset to the pointer modulo R without relying on R being a power of two.
   function automatic logic [PTR_W-1:0] f_wrap(input int v);
      int t;
      t = (v >= R) ? (v - R) : v;
      return PTR_W'(t);
   endfunction

   always_comb begin
      w_win   = r_ptr;
      w_found = 1'b0;
      for (int k = 0; k < R; k++) begin
         if (!w_found && i_req[f_wrap(int'(r_ptr) + k)]) begin
            w_found = 1'b1;
            w_win   = f_wrap(int'(r_ptr) + k);
         end
      end
   end

   assign w_cnt_last = (r_cnt == (r_len - LEN_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      o_busy         = 1'b1;
      o_lfsr_restart = 1'b0;
      o_lfsr_enable  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (w_found) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            o_lfsr_restart = 1'b1;
            w_state_nxt    = (r_len == '0) ? ST_DONE : ST_STREAM;
         end
         ST_STREAM: begin
            o_lfsr_enable = !i_hold;
            if (!i_hold && w_cnt_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Valid/last default low so any non-streaming cycle (hold, DONE) is a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_win       <= '0;
         r_val       <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_grant     <= '0;
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
         r_bit_last  <= 1'b0;
      end else begin
         r_bit_valid <= 1'b0;
         r_bit_last  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant <= {{(R-1){1'b0}}, 1'b1} << w_win;
                  r_win   <= w_win;
                  r_val   <= i_req_value[w_win*N +: N];
                  r_len   <= i_req_len[w_win*LEN_W +: LEN_W];
               end
            end
            ST_LOAD: begin
               r_cnt <= '0;
            end
            ST_STREAM: begin
               if (!i_hold) begin
                  r_bit_out   <= (i_lfsr_data < r_val);
                  r_bit_valid <= 1'b1;
                  r_bit_last  <= w_cnt_last;
                  r_cnt       <= r_cnt + LEN_W'(1);
               end
            end
            ST_DONE: begin
               r_grant <= '0;
               r_ptr   <= f_wrap(int'(r_win) + 1);
            end
            default: ;
         endcase
      end
   end

   assign o_grant     = r_grant;
   assign o_bit_out   = r_bit_out;
   assign o_bit_valid = r_bit_valid;
   assign o_bit_last  = r_bit_last;

endmodule

`default_nettype wire

// File: tb/tb_sng_scheduler.sv
// ============================================================================
// Module   : tb_sng_scheduler
// Brief    : Directed self-checking bench for sng_scheduler with an LFSR stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sng_scheduler;

   localparam int N     = 8;
   localparam int R     = 4;
   localparam int LEN_W = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [R-1:0]       i_req = '0;
   logic [R*N-1:0]     i_req_value = '0;
   logic [R*LEN_W-1:0] i_req_len = '0;
   logic               i_hold = 1'b0;
   logic [N-1:0]       i_lfsr_data;
   logic               o_lfsr_enable;
   logic               o_lfsr_restart;
   logic [R-1:0]       o_grant;
   logic               o_bit_out;
   logic               o_bit_valid;
   logic               o_bit_last;
   logic               o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // LFSR stub: a fixed state sequence, restarted to index 0 and advanced on enable.
   logic [7:0] seq [16] = '{8'd10, 8'd200, 8'd50, 8'd255, 8'd59, 8'd60, 8'd61, 8'd0,
                            8'd128, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
   int stub_idx = 0;

   always @(posedge clk) begin
      if (o_lfsr_restart)     stub_idx <= 0;
      else if (o_lfsr_enable) stub_idx <= stub_idx + 1;
   end
   assign i_lfsr_data = seq[stub_idx % 16];

   always #5 clk = ~clk;

   sng_scheduler #(.N(N), .R(R), .LEN_W(LEN_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req          (i_req),
      .i_req_value    (i_req_value),
      .i_req_len      (i_req_len),
      .i_hold         (i_hold),
      .i_lfsr_data    (i_lfsr_data),
      .o_lfsr_enable  (o_lfsr_enable),
      .o_lfsr_restart (o_lfsr_restart),
      .o_grant        (o_grant),
      .o_bit_out      (o_bit_out),
      .o_bit_valid    (o_bit_valid),
      .o_bit_last     (o_bit_last),
      .o_busy         (o_busy)
   );

   typedef struct {
      int          idx;
      logic [7:0]  val;
      logic [15:0] len;
      logic [15:0] bits;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " grant"},   32'(o_grant), 0);
      chk({tag, " bit_out"}, 32'(o_bit_out), 0);
      chk({tag, " valid"},   32'(o_bit_valid), 0);
      chk({tag, " last"},    32'(o_bit_last), 0);
      chk({tag, " busy"},    32'(o_busy), 0);
      chk({tag, " enable"},  32'(o_lfsr_enable), 0);
      chk({tag, " restart"}, 32'(o_lfsr_restart), 0);
   endtask

   task automatic set_req(input int idx, input logic [7:0] val, input logic [15:0] len);
      i_req[idx]                  = 1'b1;
      i_req_value[idx*N +: N]     = val;
      i_req_len[idx*LEN_W +: LEN_W] = len;
   endtask

   // Runs one full stream from a single requester, checking every cycle through return to IDLE.
   task automatic run_stream(input vec_t v);
      int len;
      len = int'(v.len);
      chk("idle busy", 32'(o_busy), 0);
      set_req(v.idx, v.val, v.len);
      for (int c = 1; c <= len + 3; c++) begin
         step();
         if (c == 1) begin
            i_req       = '0;
            i_req_value = ~i_req_value;
            i_req_len   = {R{16'hFFFF}};
         end
         chk("busy",    32'(o_busy),         32'(c <= len + 2));
         chk("grant",   32'(o_grant),        (c <= len + 2) ? (32'd1 << v.idx) : 32'd0);
         chk("restart", 32'(o_lfsr_restart), 32'(c == 1));
         chk("enable",  32'(o_lfsr_enable),  32'(c >= 2 && c <= len + 1));
         chk("valid",   32'(o_bit_valid),    32'(c >= 3 && c <= len + 2));
         chk("last",    32'(o_bit_last),     32'(len > 0 && c == len + 2));
         if (c >= 3 && c <= len + 2)
            chk("bit", 32'(o_bit_out), 32'(v.bits[c-3]));
      end
      chk("ptr", 32'(dut.r_ptr), 32'((v.idx + 1) % R));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #13;
      chk_all_zero("reset");
      chk("reset ptr", 32'(dut.r_ptr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      int budget;
      int saved_idx;

      tbl[0] = '{idx: 2, val: 8'd100, len: 16'd3, bits: 16'h0005};
      tbl[1] = '{idx: 0, val: 8'd0,   len: 16'd5, bits: 16'h0000};
      tbl[2] = '{idx: 3, val: 8'd60,  len: 16'd6, bits: 16'h0015};
      tbl[3] = '{idx: 1, val: 8'd200, len: 16'd0, bits: 16'h0000};
      tbl[4] = '{idx: 2, val: 8'd255, len: 16'd8, bits: 16'h00F7};

      apply_reset();
      for (int i = 0; i < 5; i++) begin
         run_stream(tbl[i]);
         step();
      end

      // Round-robin: all requesters active, len 2 each, starting from ptr 0.
      apply_reset();
      for (int i = 0; i < R; i++) set_req(i, 8'd100, 16'd2);
      for (int g = 0; g < 5; g++) begin
         budget = 20;
         while (o_grant == '0 && budget > 0) begin
            step();
            budget--;
         end
         chk("rr grant order", 32'(o_grant), 32'd1 << (g % R));
         budget = 20;
         while (o_grant != '0 && budget > 0) begin
            chk("rr onehot", 32'($onehot0(o_grant)), 1);
            step();
            budget--;
         end
         chk("rr grant drop", 32'(o_grant), 0);
         chk("rr ptr", 32'(dut.r_ptr), 32'((g + 1) % R));
         if (g == 4) i_req = '0;
      end
      step();
      step();

      // Hold: value 255, len 4, hold high in cycles 3 and 4 (ptr is 1 here).
      set_req(1, 8'd255, 16'd4);
      step();
      i_req = '0;
      step();
      step();
      chk("hold v3", 32'(o_bit_valid), 1);
      chk("hold b0", 32'(o_bit_out), 1);
      i_hold = 1'b1;
      #1;
      chk("hold en3", 32'(o_lfsr_enable), 0);
      saved_idx = stub_idx;
      step();
      chk("hold v4", 32'(o_bit_valid), 0);
      chk("hold en4", 32'(o_lfsr_enable), 0);
      chk("hold lfsr4", 32'(stub_idx), 32'(saved_idx));
      step();
      i_hold = 1'b0;
      chk("hold v5", 32'(o_bit_valid), 0);
      chk("hold lfsr5", 32'(stub_idx), 32'(saved_idx));
      step();
      chk("hold v6", 32'(o_bit_valid), 1);
      chk("hold b1", 32'(o_bit_out), 1);
      step();
      chk("hold v7", 32'(o_bit_valid), 1);
      chk("hold b2", 32'(o_bit_out), 1);
      chk("hold l7", 32'(o_bit_last), 0);
      step();
      chk("hold v8", 32'(o_bit_valid), 1);
      chk("hold b3", 32'(o_bit_out), 0);
      chk("hold l8", 32'(o_bit_last), 1);
      step();
      chk("hold idle", 32'(o_busy), 0);
      chk("hold ptr", 32'(dut.r_ptr), 2);

      // Asynchronous reset after the 4th bit of a len-10 stream.
      set_req(3, 8'd100, 16'd10);
      step();
      i_req = '0;
      for (int c = 2; c <= 6; c++) step();
      chk("rst pre valid", 32'(o_bit_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async rst");
      chk("async rst ptr", 32'(dut.r_ptr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      i_req = 4'b1001;
      i_req_len = {R{16'd1}};
      step();
      chk("post rst grant", 32'(o_grant), 32'h1);
      i_req = '0;
      budget = 20;
      while (o_busy && budget > 0) begin
         step();
         budget--;
      end
      chk("post rst idle", 32'(o_busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
